// File: rtl/multi_link_valid.sv
// Multi-channel TLK data-valid qualifier with settle timer,
// loss-of-alignment detection, per-channel mask and loss counters.
module multi_link_valid #(
   parameter int NCH        = 4,
   parameter int TIMER_W    = 10,
   parameter int SETTLE_CNT = 500,
   parameter int ERR_TOL    = 4,
   parameter int CNT_W      = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   LIVE,
   input  logic [NCH-1:0]         tlk_err,
   input  logic [NCH-1:0]         ch_mask,
   input  logic                   clr_cnt,
   output logic [NCH-1:0]         dval,
   output logic                   all_valid,
   output logic [NCH*CNT_W-1:0]   lost_cnt
);

   typedef enum logic [1:0] {
      UNALIGNED = 2'd0,
      SETTLE    = 2'd1,
      VALID     = 2'd2
   } st_e;

   localparam logic [TIMER_W-1:0] SETTLE_T = TIMER_W'(SETTLE_CNT);
   localparam logic [7:0]         TOL      = 8'(ERR_TOL);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   st_e                           st_q [NCH];
   st_e                           st_d [NCH];
   logic [NCH-1:0][TIMER_W-1:0]   timer_q, timer_d;
   logic [NCH-1:0][7:0]           run_q, run_d;
   logic [NCH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
   logic [NCH-1:0]                pipe_q, pipe_d;
   logic [NCH-1:0]                dval_q, dval_d;
   logic [NCH-1:0]                loss;
   logic [NCH-1:0]                fall;
   logic                          all_valid_q, all_valid_d;

   assign fall = pipe_q & ~tlk_err;

   // Per-channel next state: gating first, then alignment FSM and loss counting
   always_comb begin
      loss = '0;
      for (int i = 0; i < NCH; i++) begin
         st_d[i]    = st_q[i];
         timer_d[i] = timer_q[i];
         run_d[i]   = run_q[i];
         cnt_d[i]   = cnt_q[i];
         pipe_d[i]  = tlk_err[i] & LIVE & ~ch_mask[i];
         if (!LIVE || ch_mask[i]) begin
            st_d[i]    = UNALIGNED;
            timer_d[i] = '0;
            run_d[i]   = '0;
         end else begin
            unique case (st_q[i])
               UNALIGNED: begin
                  timer_d[i] = '0;
                  run_d[i]   = '0;
                  if (fall[i]) begin
                     st_d[i]    = SETTLE;
                     timer_d[i] = TIMER_W'(1);
                  end
               end
               SETTLE: begin
                  if (tlk_err[i]) begin
                     st_d[i]    = UNALIGNED;
                     timer_d[i] = '0;
                  end else if (timer_q[i] == SETTLE_T) begin
                     st_d[i]    = VALID;
                     timer_d[i] = '0;
                     run_d[i]   = '0;
                  end else begin
                     timer_d[i] = timer_q[i] + TIMER_W'(1);
                  end
               end
               VALID: begin
                  if (tlk_err[i]) begin
                     if (run_q[i] + 8'd1 == TOL) begin
                        st_d[i]  = UNALIGNED;
                        run_d[i] = '0;
                        loss[i]  = 1'b1;
                     end else begin
                        run_d[i] = run_q[i] + 8'd1;
                     end
                  end else begin
                     run_d[i] = '0;
                  end
               end
               default: begin
                  st_d[i]    = UNALIGNED;
                  timer_d[i] = '0;
                  run_d[i]   = '0;
               end
            endcase
         end
         if (loss[i] && cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
         if (clr_cnt) begin
            cnt_d[i] = '0;
         end
         dval_d[i] = (st_d[i] == VALID);
      end
      all_valid_d = (&(dval_d | ch_mask)) & LIVE;
   end

   // State, timers, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i] <= UNALIGNED;
         end
         timer_q     <= '0;
         run_q       <= '0;
         cnt_q       <= '0;
         pipe_q      <= '0;
         dval_q      <= '0;
         all_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i] <= st_d[i];
         end
         timer_q     <= timer_d;
         run_q       <= run_d;
         cnt_q       <= cnt_d;
         pipe_q      <= pipe_d;
         dval_q      <= dval_d;
         all_valid_q <= all_valid_d;
      end
   end

   assign dval      = dval_q;
   assign all_valid = all_valid_q;
   assign lost_cnt  = cnt_q;

endmodule
